// File: rtl/m_ram4_16.sv
// m_ram4_16: four-word, 16-bit register bank (RAM4).
// Four registers hold the words. A write-enable decode steers i_in into
// exactly one of them. A 4-way read mux selects the word at i_address onto
// o_out. The four stored words are also exported as taps, so a parent
// (RAM16/RAM64) or a checker can observe the whole bank without addressing it.
module m_ram4_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_load,
  input  logic [1:0]       i_address,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_word0,
  output logic [WIDTH-1:0] o_word1,
  output logic [WIDTH-1:0] o_word2,
  output logic [WIDTH-1:0] o_word3
);

  // Storage: one register per word.
  logic [WIDTH-1:0] word_q [DEPTH];

  // One-hot write enables, at most one bit set per cycle.
  logic [DEPTH-1:0] word_we;

  // First mux stage: pick inside each pair, driven by address bit 0.
  logic [WIDTH-1:0] pair_lo;
  logic [WIDTH-1:0] pair_hi;

  // Decode i_address into a one-hot write enable, gated by i_load.
  always_comb begin
    word_we = '0;
    if (i_load) begin
      unique case (i_address)
        2'd0:    word_we = 4'b0001;
        2'd1:    word_we = 4'b0010;
        2'd2:    word_we = 4'b0100;
        default: word_we = 4'b1000;
      endcase
    end
  end

  // Register update: reset clears the bank and overrides any write in the same
  // cycle. Otherwise only the enabled word loads and the rest hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) begin
          word_q[i] <= i_in;
        end
      end
    end
  end

  // Read mux, first stage: address bit 0 picks within (word0, word1) and
  // within (word2, word3).
  always_comb begin
    pair_lo = i_address[0] ? word_q[1] : word_q[0];
    pair_hi = i_address[0] ? word_q[3] : word_q[2];
  end

  // Read mux, second stage: address bit 1 picks between the pairs. The mux
  // reads register state only, so a same-address write shows the old word
  // until the edge.
  always_comb begin
    o_out = i_address[1] ? pair_hi : pair_lo;
  end

  // Taps expose the registers directly and do not depend on the address.
  always_comb begin
    o_word0 = word_q[0];
    o_word1 = word_q[1];
    o_word2 = word_q[2];
    o_word3 = word_q[3];
  end

endmodule

// File: tb/tb_m_ram4_16.sv
// Bench for m_ram4_16: directed plan steps followed by random traffic,
// checked against a plain array model of the four words.
module tb_m_ram4_16;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_in;
  logic        i_load;
  logic [1:0]  i_address;
  logic [15:0] o_out;
  logic [15:0] o_word0;
  logic [15:0] o_word1;
  logic [15:0] o_word2;
  logic [15:0] o_word3;

  // Reference model: contents of the bank.
  logic [15:0] mdl [4];

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  m_ram4_16 dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_in      (i_in),
    .i_load    (i_load),
    .i_address (i_address),
    .o_out     (o_out),
    .o_word0   (o_word0),
    .o_word1   (o_word1),
    .o_word2   (o_word2),
    .o_word3   (o_word3)
  );

  // Clock: 10 ns period. Rising edges fall at 5, 15, 25, ...
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, take the edge, then update the model from the
  // rules: reset beats load, and load writes exactly the addressed word.
  task automatic cycle(input logic rst, input logic ld, input logic [1:0] addr,
                       input logic [15:0] din);
    i_reset   = rst;
    i_load    = ld;
    i_address = addr;
    i_in      = din;
    @(posedge i_clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 4; k++) mdl[k] = 16'h0000;
    end else if (ld) begin
      mdl[addr] = din;
    end
  endtask

  // Compare the four taps and the read port at the current address.
  task automatic chk_state(input string tag);
    #1;
    chk({tag, "/w0"}, o_word0, mdl[0]);
    chk({tag, "/w1"}, o_word1, mdl[1]);
    chk({tag, "/w2"}, o_word2, mdl[2]);
    chk({tag, "/w3"}, o_word3, mdl[3]);
    chk({tag, "/out"}, o_out, mdl[i_address]);
  endtask

  // Sweep the read address 0..3 inside one clock phase, with load off.
  task automatic sweep(input string tag);
    i_load = 1'b0;
    for (int a = 0; a < 4; a++) begin
      i_address = 2'(a);
      #1;
      chk($sformatf("%s/rd%0d", tag, a), o_out, mdl[a]);
    end
  endtask

  initial begin
    i_reset   = 1'b1;
    i_load    = 1'b0;
    i_address = 2'd0;
    i_in      = 16'h0000;
    for (int k = 0; k < 4; k++) mdl[k] = 16'h0000;

    // Establish a defined bank before anything is checked.
    cycle(1'b1, 1'b0, 2'd0, 16'h0000);
    chk_state("init_reset");

    // Step 1: fill with 0xFFFF, then reset.
    for (int a = 0; a < 4; a++) cycle(1'b0, 1'b1, 2'(a), 16'hFFFF);
    chk_state("fill_ffff");
    chk("fill_ffff/const", o_word2, 16'hFFFF);
    cycle(1'b1, 1'b0, 2'd2, 16'h0000);
    chk_state("reset");
    sweep("reset");
    chk("reset/const_w3", o_word3, 16'h0000);

    // Step 2: write each word, then read back.
    cycle(1'b0, 1'b1, 2'd0, 16'h1234);
    cycle(1'b0, 1'b1, 2'd1, 16'hABCD);
    cycle(1'b0, 1'b1, 2'd2, 16'h8000);
    cycle(1'b0, 1'b1, 2'd3, 16'h7FFF);
    sweep("readback");
    i_address = 2'd0; #1; chk("readback/c0", o_out, 16'h1234);
    i_address = 2'd1; #1; chk("readback/c1", o_out, 16'hABCD);
    i_address = 2'd2; #1; chk("readback/c2", o_out, 16'h8000);
    i_address = 2'd3; #1; chk("readback/c3", o_out, 16'h7FFF);

    // Step 3: hold for 5 edges with noise on i_in.
    for (int n = 0; n < 5; n++) cycle(1'b0, 1'b0, 2'd2, 16'hDEAD);
    chk_state("hold");
    chk("hold/w2_const", o_word2, 16'h8000);

    // Step 4: read during write at the same address.
    i_reset = 1'b0; i_load = 1'b1; i_address = 2'd1; i_in = 16'h5555;
    #1;
    chk("rdw/before", o_out, 16'hABCD);
    cycle(1'b0, 1'b1, 2'd1, 16'h5555);
    i_load = 1'b0;
    #1;
    chk("rdw/after", o_out, 16'h5555);
    chk_state("rdw");

    // Step 5: reset and load at the same edge, so the write is dropped.
    cycle(1'b1, 1'b1, 2'd3, 16'h9999);
    i_reset = 1'b0; i_load = 1'b0;
    chk_state("rst_vs_load");
    chk("rst_vs_load/w3", o_word3, 16'h0000);

    // Step 6: back-to-back writes to alternating addresses.
    cycle(1'b0, 1'b1, 2'd1, 16'h0B0B);
    cycle(1'b0, 1'b1, 2'd2, 16'h0C0C);
    cycle(1'b0, 1'b1, 2'd0, 16'h0001);
    cycle(1'b0, 1'b1, 2'd3, 16'h0003);
    cycle(1'b0, 1'b1, 2'd0, 16'h0010);
    i_load = 1'b0;
    chk_state("b2b");
    chk("b2b/w0", o_word0, 16'h0010);
    chk("b2b/w3", o_word3, 16'h0003);
    chk("b2b/w1", o_word1, 16'h0B0B);
    chk("b2b/w2", o_word2, 16'h0C0C);

    // Random traffic: mostly writes, occasional reset, plus a read at a
    // random address before each edge to check the old value is still shown.
    for (int n = 0; n < 300; n++) begin
      logic        r_rst;
      logic        r_ld;
      logic [1:0]  r_addr;
      logic [15:0] r_din;
      logic [1:0]  peek;
      r_rst  = ($urandom_range(0, 31) == 0);
      r_ld   = ($urandom_range(0, 3) != 0);
      r_addr = 2'($urandom_range(0, 3));
      r_din  = 16'($urandom);
      peek   = 2'($urandom_range(0, 3));
      i_reset = 1'b0; i_load = r_ld; i_in = r_din; i_address = peek;
      #1;
      chk("rand/peek", o_out, mdl[peek]);
      cycle(r_rst, r_ld, r_addr, r_din);
      chk_state("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
